nnacc_sync_fifo: RTL

- Parametrised synchronous FIFO that succeeds the single-entry accelerator FIFO.
- Adds configurable width and depth, and two read modes: registered (standard) and first-word-fall-through.
- Adds almost-full/almost-empty thresholds, an occupancy count and sticky overflow/underflow error flags.
- Sits between NN accelerator pipeline stages, e.g. weight/activation staging and result drain.

---
 rtl/nnacc_sync_fifo.sv | 81 ++++++++
 1 files changed

// File: rtl/nnacc_sync_fifo.sv
// nnacc_sync_fifo: parametrised synchronous FIFO with standard or first-word-fall-through read
module nnacc_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0,
  parameter int AFULL_TH   = 12,
  parameter int AEMPTY_TH  = 2
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AFULL_TH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AEMPTY_TH);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  rv_q, rv_d, ovf_q, ovf_d, udf_q, udf_d;
  logic                  wr_acc, rd_acc;
  assign full         = count_q == DEPTH_C;
  assign empty        = count_q == '0;
  assign almost_full  = count_q >= AF_C;
  assign almost_empty = count_q <= AE_C;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;
  assign wr_acc       = wr_en & ~full;
  assign rd_acc       = rd_en & ~empty;
  // In FWFT mode the head word is presented straight from storage; otherwise a popped word is registered
  assign data_out     = (FWFT != 0) ? mem_q[rd_ptr_q] : dout_q;
  assign rd_valid     = (FWFT != 0) ? ~empty : rv_q;
  // Next-state: pointers wrap naturally, count moves only on an unmatched access, errors are sticky with set winning over clear
  always_comb begin
    wr_ptr_d = wr_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = rd_acc ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = (wr_acc & ~rd_acc) ? count_q + 1'b1 : (rd_acc & ~wr_acc) ? count_q - 1'b1 : count_q;
    dout_d   = (rd_acc && FWFT == 0) ? mem_q[rd_ptr_q] : dout_q;
    rv_d     = rd_acc && FWFT == 0;
    ovf_d    = (wr_en & full) | (ovf_q & ~clr_err);
    udf_d    = (rd_en & empty) | (udf_q & ~clr_err);
  end
  // Storage array, deliberately left out of reset
  always_ff @(posedge sys_clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= data_in;
  end
  // Control and output registers; reset overrides any access in the same cycle
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      rv_q     <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      rv_q     <= rv_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end
endmodule
